ssd1331_init_sequencer: RTL

Power-up and initialisation controller for the SSD1331 OLED, sitting directly upstream of `Nbit_MOSI_SPI_Buffer`. It drives the panel power and reset pins through the datasheet power-on timing. It loads fixed command groups, up to 8 bytes each, into the buffer's data/DC/count inputs, and waits for each SPI transfer to finish. When the display is on, it asserts `o_READY` so the drawing logic can take over the buffer.

---
 rtl/ssd1331_init_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ssd1331_init_sequencer.sv
// SSD1331 power-up sequencer: steps the panel through its power/reset timing, streams
// the fixed init command groups into the SPI buffer, then hands the bus over via o_READY.
module ssd1331_init_sequencer #(
  parameter int WIDTH  = 8,
  parameter int N      = 8,
  parameter int T_PMOD = 125000,
  parameter int T_RES  = 20,
  parameter int T_VCC  = 156250,
  parameter int T_ON   = 625000
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_TX_DONE,
  output logic [N*WIDTH-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [4:0]         o_N_transmit,
  output logic               o_START,
  output logic               o_PMODEN,
  output logic               o_RES_n,
  output logic               o_VCCEN,
  output logic               o_READY
);

  typedef enum logic [2:0] {
    S_PMOD,
    S_RES_LO,
    S_RES_HI,
    S_LOAD,
    S_WAIT_TX,
    S_VCC,
    S_ON,
    S_READY
  } state_t;

  localparam logic [19:0] PMOD_LD = 20'(T_PMOD - 1);
  localparam logic [19:0] RES_LD  = 20'(T_RES - 1);
  localparam logic [19:0] VCC_LD  = 20'(T_VCC - 1);
  localparam logic [19:0] ON_LD   = 20'(T_ON - 1);

  state_t             state;
  logic [19:0]        timer;
  logic [2:0]         grp_idx;
  logic [7:0]         rom_byte [8];
  logic [4:0]         grp_len;
  logic [N*WIDTH-1:0] grp_data;

  // Command group ROM; unused byte slots stay 00 so the buffer never sees stale bytes.
  always_comb begin
    for (int k = 0; k < 8; k++) rom_byte[k] = 8'h00;
    grp_len = 5'd0;
    case (grp_idx)
      3'd0: begin
        rom_byte[0] = 8'hFD; rom_byte[1] = 8'h12;
        grp_len = 5'd2;
      end
      3'd1: begin
        rom_byte[0] = 8'hAE;
        grp_len = 5'd1;
      end
      3'd2: begin
        rom_byte[0] = 8'hA0; rom_byte[1] = 8'h72; rom_byte[2] = 8'hA1;
        rom_byte[3] = 8'h00; rom_byte[4] = 8'hA2; rom_byte[5] = 8'h00;
        grp_len = 5'd6;
      end
      3'd3: begin
        rom_byte[0] = 8'hA4; rom_byte[1] = 8'hA8; rom_byte[2] = 8'h3F;
        rom_byte[3] = 8'hAD; rom_byte[4] = 8'h8E;
        grp_len = 5'd5;
      end
      3'd4: begin
        rom_byte[0] = 8'hB0; rom_byte[1] = 8'h0B; rom_byte[2] = 8'hB1;
        rom_byte[3] = 8'h31; rom_byte[4] = 8'hB3; rom_byte[5] = 8'hF0;
        grp_len = 5'd6;
      end
      3'd5: begin
        rom_byte[0] = 8'h87; rom_byte[1] = 8'h06; rom_byte[2] = 8'h81;
        rom_byte[3] = 8'h91; rom_byte[4] = 8'h82; rom_byte[5] = 8'h50;
        rom_byte[6] = 8'h83; rom_byte[7] = 8'h7D;
        grp_len = 5'd8;
      end
      3'd6: begin
        rom_byte[0] = 8'hAF;
        grp_len = 5'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    grp_data = '0;
    for (int k = 0; k < N && k < 8; k++)
      grp_data[k*WIDTH +: WIDTH] = WIDTH'(rom_byte[k[2:0]]);
  end

  // Outputs registered on each edge reflect the state being executed at that edge,
  // so every delay state spans exactly its parameter in cycles.
  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state        <= S_PMOD;
      timer        <= PMOD_LD;
      grp_idx      <= 3'd0;
      o_DATA       <= '0;
      o_DC         <= '0;
      o_N_transmit <= 5'd0;
      o_START      <= 1'b0;
      o_PMODEN     <= 1'b0;
      o_RES_n      <= 1'b1;
      o_VCCEN      <= 1'b0;
      o_READY      <= 1'b0;
    end else begin
      o_START <= 1'b0;
      o_RES_n <= 1'b1;
      case (state)
        S_PMOD: begin
          o_PMODEN <= 1'b1;
          if (timer == 20'd0) begin
            state <= S_RES_LO;
            timer <= RES_LD;
          end else begin
            timer <= timer - 20'd1;
          end
        end
        S_RES_LO: begin
          o_RES_n <= 1'b0;
          if (timer == 20'd0) begin
            state <= S_RES_HI;
            timer <= RES_LD;
          end else begin
            timer <= timer - 20'd1;
          end
        end
        S_RES_HI: begin
          if (timer == 20'd0) state <= S_LOAD;
          else                timer <= timer - 20'd1;
        end
        S_LOAD: begin
          o_DATA       <= grp_data;
          o_DC         <= '0;
          o_N_transmit <= grp_len;
          o_START      <= 1'b1;
          state        <= S_WAIT_TX;
        end
        // Group 5 ends the pre-VCC batch; group 6 is display-on and ends the sequence.
        S_WAIT_TX: begin
          if (i_TX_DONE) begin
            if (grp_idx < 3'd5) begin
              grp_idx <= grp_idx + 3'd1;
              state   <= S_LOAD;
            end else if (grp_idx == 3'd5) begin
              grp_idx <= 3'd6;
              state   <= S_VCC;
              timer   <= VCC_LD;
            end else begin
              state <= S_ON;
              timer <= ON_LD;
            end
          end
        end
        S_VCC: begin
          o_VCCEN <= 1'b1;
          if (timer == 20'd0) state <= S_LOAD;
          else                timer <= timer - 20'd1;
        end
        S_ON: begin
          if (timer == 20'd0) state <= S_READY;
          else                timer <= timer - 20'd1;
        end
        S_READY: begin
          o_READY      <= 1'b1;
          o_DATA       <= '0;
          o_DC         <= '0;
          o_N_transmit <= 5'd0;
        end
        default: state <= S_PMOD;
      endcase
    end
  end

endmodule
